// File: rtl/interface_hcsr04_uc_if.sv
// Control/status bundle between the HC-SR04 control unit and its environment.
// master = datapath/sensor side, slave = control unit side.
interface interface_hcsr04_uc_if;
  logic       medir;
  logic       echo;
  logic       fim_medida;
  logic       fim;
  logic       zera;
  logic       gera;
  logic       registra;
  logic       pronto;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    output medir, echo, fim_medida, fim,
    input  zera, gera, registra, pronto, timeout, db_estado
  );

  modport slave (
    input  medir, echo, fim_medida, fim,
    output zera, gera, registra, pronto, timeout, db_estado
  );
endinterface

// File: rtl/interface_hcsr04_uc.sv
// Moore control unit for the HC-SR04 interface: clear, trigger, wait echo, capture, register.
// Define HCSR04_WATCHDOG_EN to build the echo watchdog, the erro state and the timeout flag.
module interface_hcsr04_uc #(
  parameter int TIMEOUT_CICLOS = 3000000,
  parameter int TW             = 22
) (
  input logic                  clock,
  input logic                  reset,
  interface_hcsr04_uc_if.slave bus
);

  typedef enum logic [3:0] {
    st_inicial       = 4'b0000,
    st_preparacao    = 4'b0001,
    st_envia_trigger = 4'b0010,
    st_espera_echo   = 4'b0011,
    st_medida        = 4'b0100,
    st_armazenamento = 4'b0101,
    st_final_medida  = 4'b0110,
    st_erro          = 4'b1111
  } state_e;

  // Reject a counter too narrow to ever reach the limit.
  if (TIMEOUT_CICLOS < 1 || (64'(1) << TW) <= 64'(TIMEOUT_CICLOS)) begin : g_bad_cfg
    $error("interface_hcsr04_uc: TW too small for TIMEOUT_CICLOS");
  end

  state_e state_q, state_d;

`ifdef HCSR04_WATCHDOG_EN
  logic [TW-1:0] wd_q, wd_d;
  logic          timeout_q, timeout_d;
  logic          wd_fire;

  assign wd_fire = (wd_q == TW'(TIMEOUT_CICLOS - 1));
`endif

  // NOTE: every variable gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d = st_inicial;
    case (state_q)
      st_inicial:       state_d = bus.medir ? st_preparacao : st_inicial;
      st_preparacao:    state_d = st_envia_trigger;
      st_envia_trigger: state_d = st_espera_echo;
      st_espera_echo: begin
        if (bus.echo) state_d = st_medida;
`ifdef HCSR04_WATCHDOG_EN
        else if (wd_fire) state_d = st_erro;
`endif
        else state_d = st_espera_echo;
      end
      st_medida: begin
        // Completion has priority over a watchdog fire in the same cycle.
        if (bus.fim_medida || bus.fim) state_d = st_armazenamento;
`ifdef HCSR04_WATCHDOG_EN
        else if (wd_fire) state_d = st_erro;
`endif
        else state_d = st_medida;
      end
      st_armazenamento: state_d = st_final_medida;
      st_final_medida:  state_d = st_inicial;
`ifdef HCSR04_WATCHDOG_EN
      st_erro:          state_d = st_inicial;
`endif
      default:          state_d = st_inicial;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= st_inicial;
    else        state_q <= state_d;
  end

`ifdef HCSR04_WATCHDOG_EN
  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if (state_q == st_envia_trigger)
      wd_d = '0;
    else if (state_q == st_espera_echo || state_q == st_medida)
      wd_d = wd_q + TW'(1);
    if (state_q == st_preparacao)
      timeout_d = 1'b0;
    else if (state_q == st_erro)
      timeout_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.zera      = (state_q == st_preparacao);
  assign bus.gera      = (state_q == st_envia_trigger);
  assign bus.registra  = (state_q == st_armazenamento);
  assign bus.pronto    = (state_q == st_final_medida);
  assign bus.db_estado = state_q;

endmodule

// File: tb/tb_interface_hcsr04_uc.sv
// Self-checking bench for interface_hcsr04_uc: vector table plus directed watchdog/reset sequences.
// Watchdog sequences run when HCSR04_WATCHDOG_EN is defined; otherwise the endless-wait case runs.
module tb_interface_hcsr04_uc;
  localparam int TO = 1000;
  localparam int TWW = 10;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  interface_hcsr04_uc_if bus ();

  interface_hcsr04_uc #(.TIMEOUT_CICLOS(TO), .TW(TWW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       medir;
    logic       echo;
    logic       fim_medida;
    logic       fim;
    logic [3:0] exp_st;
  } vec_t;

  vec_t vecs[20];

  // Expected {timeout, pronto, registra, gera, zera, db_estado} for a state code.
  function automatic logic [8:0] exp_out(input logic [3:0] st, input logic to);
    return {to, st == 4'd6, st == 4'd5, st == 4'd2, st == 4'd1, st};
  endfunction

  function automatic logic [8:0] obs();
    return {bus.timeout, bus.pronto, bus.registra, bus.gera, bus.zera, bus.db_estado};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic m, input logic e, input logic fm, input logic f);
    bus.medir = m; bus.echo = e; bus.fim_medida = fm; bus.fim = f;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string name);
    reset = 1'b0;
    #1;
    check(name, 32'(obs()), 32'(exp_out(4'd0, 1'b0)));
    drive(0, 0, 0, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // From inicial: request, then observe preparacao, envia_trigger and entry into espera_echo.
  task automatic start_meas(input string name);
    drive(1, 0, 0, 0);
    step();
    check({name, "_prep"}, 32'(bus.db_estado), 32'd1);
    drive(0, 0, 0, 0);
    step();
    check({name, "_gera"}, 32'(obs()), 32'(exp_out(4'd2, 1'b0)));
    step();
    check({name, "_entry"}, 32'(obs()), 32'(exp_out(4'd3, 1'b0)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not end");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int bad;
    bit seen_reg;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd3};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd4};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd4};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd5};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd6};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd2};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd3};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd4};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd5};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd6};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3};

    reset = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_hold", 32'(obs()), 32'(exp_out(4'd0, 1'b0)));
    reset = 1'b1;

    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs() !== exp_out(4'd0, 1'b0)) bad++;
    end
    check("idle_10_cycles_bad", 32'(bad), 32'd0);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].medir, vecs[i].echo, vecs[i].fim_medida, vecs[i].fim);
      step();
      check($sformatf("vec%0d", i), 32'(obs()), 32'(exp_out(vecs[i].exp_st, 1'b0)));
    end

    drive(0, 1, 0, 0);
    step();
    check("pre_rst_medida", 32'(obs()), 32'(exp_out(4'd4, 1'b0)));
    do_reset("rst_in_medida");

    // Nominal: echo 20 cycles after gera, fim_medida after 100 cycles of echo.
    start_meas("nom");
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (bus.db_estado !== 4'd3) bad++;
    end
    check("nom_wait_echo_bad", 32'(bad), 32'd0);
    drive(0, 1, 0, 0);
    step();
    check("nom_medida", 32'(obs()), 32'(exp_out(4'd4, 1'b0)));
    bad = 0;
    for (int i = 0; i < 99; i++) begin
      step();
      if (obs() !== exp_out(4'd4, 1'b0)) bad++;
    end
    check("nom_hold_medida_bad", 32'(bad), 32'd0);
    drive(0, 0, 1, 0);
    step();
    check("nom_registra", 32'(obs()), 32'(exp_out(4'd5, 1'b0)));
    drive(0, 0, 0, 0);
    step();
    check("nom_pronto", 32'(obs()), 32'(exp_out(4'd6, 1'b0)));
    step();
    check("nom_back_idle", 32'(obs()), 32'(exp_out(4'd0, 1'b0)));

    drive(1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0);
    step();
    check("pre_rst_gera", 32'(obs()), 32'(exp_out(4'd2, 1'b0)));
    do_reset("rst_in_gera");
    step();
    check("after_rst_gera_idle", 32'(obs()), 32'(exp_out(4'd0, 1'b0)));

`ifdef HCSR04_WATCHDOG_EN
    // Echo never arrives: erro exactly TO edges after entering espera_echo.
    start_meas("to");
    n = 0;
    for (int i = 0; i < TO + 50; i++) begin
      step();
      n++;
      if (bus.db_estado !== 4'd3) break;
    end
    check("to_cycles", 32'(n), 32'(TO));
    check("to_erro", 32'(obs()), 32'(exp_out(4'd15, 1'b0)));
    step();
    check("to_flag_set", 32'(obs()), 32'(exp_out(4'd0, 1'b1)));
    step();
    check("to_flag_sticky", 32'(obs()), 32'(exp_out(4'd0, 1'b1)));
    start_meas("to_clear");

    // Stuck echo: enters medida, no completion, erro at TO edges and no registra.
    drive(0, 1, 0, 0);
    step();
    check("stuck_medida", 32'(obs()), 32'(exp_out(4'd4, 1'b0)));
    n = 1;
    seen_reg = 1'b0;
    for (int i = 0; i < TO + 50; i++) begin
      step();
      n++;
      if (bus.registra) seen_reg = 1'b1;
      if (bus.db_estado !== 4'd4) break;
    end
    check("stuck_cycles", 32'(n), 32'(TO));
    check("stuck_erro", 32'(obs()), 32'(exp_out(4'd15, 1'b0)));
    check("stuck_no_registra", 32'(seen_reg), 32'd0);
    drive(0, 0, 0, 0);
    step();
    check("stuck_flag", 32'(obs()), 32'(exp_out(4'd0, 1'b1)));

    // fim_medida on the watchdog firing cycle: completion wins.
    start_meas("conf");
    drive(0, 1, 0, 0);
    step();
    bad = 0;
    for (int i = 2; i < TO; i++) begin
      step();
      if (bus.db_estado !== 4'd4) bad++;
    end
    check("conf_hold_bad", 32'(bad), 32'd0);
    drive(0, 1, 1, 0);
    step();
    check("conf_armazena", 32'(obs()), 32'(exp_out(4'd5, 1'b0)));
    drive(0, 0, 0, 0);
    step();
    step();
    check("conf_idle_no_to", 32'(obs()), 32'(exp_out(4'd0, 1'b0)));

    // echo on the watchdog firing cycle in espera_echo: echo wins.
    start_meas("econf");
    for (int i = 1; i < TO; i++) step();
    check("econf_still_wait", 32'(obs()), 32'(exp_out(4'd3, 1'b0)));
    drive(0, 1, 0, 0);
    step();
    check("econf_medida", 32'(obs()), 32'(exp_out(4'd4, 1'b0)));
    drive(0, 0, 0, 1);
    step();
    check("econf_fim_registra", 32'(obs()), 32'(exp_out(4'd5, 1'b0)));
    drive(0, 0, 0, 0);
    step();
    check("econf_pronto", 32'(obs()), 32'(exp_out(4'd6, 1'b0)));
    step();
    check("econf_idle", 32'(obs()), 32'(exp_out(4'd0, 1'b0)));
`else
    // Without the watchdog espera_echo waits forever and timeout stays 0.
    start_meas("nowd");
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (obs() !== exp_out(4'd3, 1'b0)) bad++;
    end
    check("nowd_wait_bad", 32'(bad), 32'd0);
    check("nowd_state", 32'(obs()), 32'(exp_out(4'd3, 1'b0)));
`endif

    do_reset("rst_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/interface_hcsr04_uc.md
# interface_hcsr04_uc

Control unit for the HC-SR04 ultrasonic interface. It sequences the interface datapath through one measurement per `medir` request: clear, trigger, wait for echo, capture, register. It drives the datapath's `zera`, `gera` and `registra` strobes and consumes its `fim_medida` and `fim` flags. It also supervises the echo with a watchdog so that a missing or stuck sensor cannot hang the system.

## Interface
Parameters:
- `TIMEOUT_CICLOS`, default 3000000: watchdog limit in clocks (60 ms at 50 MHz), measured from entry into `espera_echo`.
- `TW`, default 22: watchdog counter width; must satisfy 2^TW > TIMEOUT_CICLOS.

Ports:
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `medir`  in  1  measurement request, level; sampled only in `inicial`.
- `echo`  in  1  sensor echo line, already synchronized upstream.
- `fim_medida`  in  1  datapath: echo-width count complete.
- `fim`  in  1  datapath: distance counter saturated.
- `zera`  out  1  datapath clear strobe.
- `gera`  out  1  trigger-pulse start strobe.
- `registra`  out  1  distance register load strobe.
- `pronto`  out  1  one-cycle "new distance valid".
- `timeout`  out  1  sticky watchdog error flag.
- `db_estado`  out  4  current state code, for debug displays.

## Operation
- Moore FSM with a 4-bit state register. All strobes decode from the state only.
- State codes and behaviour:
  - `inicial` 0000: all strobes 0. If `medir`=1, go to `preparacao`.
  - `preparacao` 0001: `zera`=1 for one cycle. Clears the `timeout` flag. Go to `envia_trigger`.
  - `envia_trigger` 0010: `gera`=1 for one cycle. Go to `espera_echo`. The watchdog counter loads 0.
  - `espera_echo` 0011: if `echo`=1, go to `medida`. Else if the watchdog fires, go to `erro`.
  - `medida` 0100: if `fim_medida`=1 or `fim`=1, go to `armazenamento`. Else if the watchdog fires, go to `erro`.
  - `armazenamento` 0101: `registra`=1 for one cycle. Go to `final_medida`.
  - `final_medida` 0110: `pronto`=1 for one cycle. Go to `inicial`.
  - `erro` 1111: sets the `timeout` flag. Go to `inicial`.
- Watchdog:
  - Increments every cycle in `espera_echo` and `medida`; holds its value in all other states.
  - Fires when count = TIMEOUT_CICLOS-1.
- `medir` is ignored outside `inicial`. If `medir` is held high, measurements repeat back-to-back.
- `db_estado` equals the state code.

## Timing
- Reset (asynchronous, `reset`=0):
  - State goes to `inicial`, watchdog to 0, `timeout` flag to 0.
  - All outputs read 0, and `db_estado`=0000.
  - This applies mid-operation too: a `gera` pulse in progress is cut immediately.
- Latency from `medir` sampled high in `inicial`:
  - `zera` at +1 cycle, `gera` at +2.
  - First `echo` sampling at +3.
- From `fim_medida` sampled in `medida`:
  - `registra` at +1 cycle, `pronto` at +2.
  - `distancia` is valid in the datapath in the same cycle `pronto` is high.
- `echo` already high on entry to `espera_echo`: transition at the next edge. No edge detection.
- Same-cycle conflicts:
  - `fim_medida` or `fim` together with a watchdog fire in `medida`: completion wins, go to `armazenamento`.
  - `echo` together with a watchdog fire in `espera_echo`: `echo` wins.
- Successful measurement time: 6 cycles plus echo delay plus echo width.
- Timeout path: `erro` is reached exactly TIMEOUT_CICLOS cycles after entering `espera_echo`. `timeout` goes high one cycle after `erro` and stays high until the next `preparacao`.
- Unused codes 0111–1110 go to `inicial` on the next edge.

## Configuration
- `HCSR04_WATCHDOG_EN` defined:
  - Watchdog counter, the `erro` state and the `timeout` flag are compiled in, as described above.
- `HCSR04_WATCHDOG_EN` undefined:
  - No counter or `erro` logic is built, and `timeout` is tied to 0.
  - `espera_echo` and `medida` wait indefinitely.
  - Code 1111 is treated as an unused code.

## Test plan
- Reset and idle: hold `reset`=0, then release with `medir`=0 for 10 cycles. Expect all outputs 0, `db_estado`=0000 throughout.
- Nominal measurement: pulse `medir` one cycle; raise `echo` 20 cycles after `gera`; assert `fim_medida` 100 cycles later. Expect:
  - the sequence `zera`, `gera`, then `db_estado` 0011→0100;
  - `registra` one cycle after `fim_medida`, then `pronto` one cycle later;
  - back to 0000.
- Echo timeout: TIMEOUT_CICLOS=1000 with `echo` held 0. Expect `erro` exactly 1000 cycles after entering 0011, then `timeout`=1. The next `medir` clears `timeout` in `preparacao`.
- Stuck echo: `echo` rises but `fim_medida` never comes, TIMEOUT_CICLOS=1000. Expect `erro` 1000 cycles after entering 0011 and no `registra`.
- Conflict and saturation: assert `fim_medida` on the watchdog's firing cycle. Expect `armazenamento`, not `erro`. Separately, assert `fim` alone in `medida`. Expect `registra` then `pronto`.
- Reset mid-operation: drive `reset`=0 during the `gera` cycle and during `medida`. Expect an immediate return to 0000 with all strobes 0. With `HCSR04_WATCHDOG_EN` undefined, `echo`=0 for 10000 cycles stays in 0011 with `timeout`=0.
